// File: rtl/jtag_pkg.sv
// Shared TAP definitions: state encoding, default instruction codes and the
// IEEE 1149.1 next-state function used by the responder.
package jtag_pkg;

   typedef enum logic [3:0] {
      TLR        = 4'd0,
      RTI        = 4'd1,
      SELECT_DR  = 4'd2,
      CAPTURE_DR = 4'd3,
      SHIFT_DR   = 4'd4,
      EXIT1_DR   = 4'd5,
      PAUSE_DR   = 4'd6,
      EXIT2_DR   = 4'd7,
      UPDATE_DR  = 4'd8,
      SELECT_IR  = 4'd9,
      CAPTURE_IR = 4'd10,
      SHIFT_IR   = 4'd11,
      EXIT1_IR   = 4'd12,
      PAUSE_IR   = 4'd13,
      EXIT2_IR   = 4'd14,
      UPDATE_IR  = 4'd15
   } tap_state_t;

   localparam logic [7:0]  DEFAULT_INSN_IDCODE  = 8'h01;
   localparam logic [7:0]  DEFAULT_INSN_USER    = 8'h02;
   localparam logic [31:0] DEFAULT_IDCODE_VALUE = 32'h1234_5679;

   function automatic tap_state_t tap_next_state(input tap_state_t s, input logic tms);
      tap_state_t n;
      n = TLR;
      case (s)
         TLR:        n = tms ? TLR       : RTI;
         RTI:        n = tms ? SELECT_DR : RTI;
         SELECT_DR:  n = tms ? SELECT_IR : CAPTURE_DR;
         CAPTURE_DR: n = tms ? EXIT1_DR  : SHIFT_DR;
         SHIFT_DR:   n = tms ? EXIT1_DR  : SHIFT_DR;
         EXIT1_DR:   n = tms ? UPDATE_DR : PAUSE_DR;
         PAUSE_DR:   n = tms ? EXIT2_DR  : PAUSE_DR;
         EXIT2_DR:   n = tms ? UPDATE_DR : SHIFT_DR;
         UPDATE_DR:  n = tms ? SELECT_DR : RTI;
         SELECT_IR:  n = tms ? TLR       : CAPTURE_IR;
         CAPTURE_IR: n = tms ? EXIT1_IR  : SHIFT_IR;
         SHIFT_IR:   n = tms ? EXIT1_IR  : SHIFT_IR;
         EXIT1_IR:   n = tms ? UPDATE_IR : PAUSE_IR;
         PAUSE_IR:   n = tms ? EXIT2_IR  : PAUSE_IR;
         EXIT2_IR:   n = tms ? UPDATE_IR : SHIFT_IR;
         UPDATE_IR:  n = tms ? SELECT_DR : RTI;
         default:    n = TLR;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/jtag_edge_sync.sv
// Brings TCK/TMS/TDI into the ref_clk domain through matched two-flop stages
// and produces single-cycle TCK rising/falling edge strobes.
module jtag_edge_sync (
   input  logic ref_clk,
   input  logic rst,
   input  logic tck,
   input  logic tms,
   input  logic tdi,
   output logic tck_rise,
   output logic tck_fall,
   output logic tms_s,
   output logic tdi_s
);

   // Bit order {tdi, tms, tck}; all three share the same latency.
   logic [2:0] meta_q, meta_d;
   logic [2:0] sync_q, sync_d;
   logic       tck_prev_q, tck_prev_d;

   always_comb begin
      meta_d     = {tdi, tms, tck};
      sync_d     = meta_q;
      tck_prev_d = sync_q[0];
   end

   always_ff @(posedge ref_clk or posedge rst) begin
      if (rst) begin
         meta_q     <= 3'b000;
         sync_q     <= 3'b000;
         tck_prev_q <= 1'b0;
      end else begin
         meta_q     <= meta_d;
         sync_q     <= sync_d;
         tck_prev_q <= tck_prev_d;
      end
   end

   assign tck_rise = sync_q[0] & ~tck_prev_q;
   assign tck_fall = ~sync_q[0] & tck_prev_q;
   assign tms_s    = sync_q[1];
   assign tdi_s    = sync_q[2];

endmodule

// File: rtl/jtag_tap_responder.sv
// Target-side JTAG TAP: oversampled TCK, 16-state TAP FSM, IR plus
// IDCODE/USER/BYPASS data registers shifted LSB-first.
module jtag_tap_responder
   import jtag_pkg::*;
#(
   parameter int                 IR_LEN       = 8,
   parameter int                 DR_LEN       = 32,
   parameter logic [31:0]        IDCODE_VALUE = DEFAULT_IDCODE_VALUE,
   parameter logic [IR_LEN-1:0]  INSN_IDCODE  = IR_LEN'(DEFAULT_INSN_IDCODE),
   parameter logic [IR_LEN-1:0]  INSN_USER    = IR_LEN'(DEFAULT_INSN_USER)
) (
   input  logic              ref_clk,
   input  logic              rst,
   input  logic              tck,
   input  logic              tms,
   input  logic              tdi,
   output logic              tdo,
   output logic [3:0]        tap_state,
   output logic [IR_LEN-1:0] ir_value,
   input  logic [DR_LEN-1:0] dr_capture_in,
   output logic [DR_LEN-1:0] user_dr_out,
   output logic              user_dr_update
);

   logic tck_rise, tck_fall, tms_s, tdi_s;

   jtag_edge_sync u_edge_sync (
      .ref_clk  (ref_clk),
      .rst      (rst),
      .tck      (tck),
      .tms      (tms),
      .tdi      (tdi),
      .tck_rise (tck_rise),
      .tck_fall (tck_fall),
      .tms_s    (tms_s),
      .tdi_s    (tdi_s)
   );

   tap_state_t        state_q, state_d;
   logic [IR_LEN-1:0] ir_shift_q, ir_shift_d;
   logic [31:0]       idcode_shift_q, idcode_shift_d;
   logic [DR_LEN-1:0] user_shift_q, user_shift_d;
   logic              bypass_q, bypass_d;
   logic              tdo_q, tdo_d;
   logic [IR_LEN-1:0] ir_value_q, ir_value_d;
   logic [DR_LEN-1:0] user_dr_out_q, user_dr_out_d;
   logic              user_dr_update_q, user_dr_update_d;
   logic              upd_ir_pend_q, upd_ir_pend_d;
   logic              upd_dr_pend_q, upd_dr_pend_d;

   logic sel_idcode, sel_user, dr_bit0;

   assign sel_idcode = (ir_value_q == INSN_IDCODE);
   assign sel_user   = (ir_value_q == INSN_USER);
   assign dr_bit0    = sel_idcode ? idcode_shift_q[0] :
                       sel_user   ? user_shift_q[0]   : bypass_q;

   // Updates commit one ref_clk after the FSM lands in an Update state,
   // tracked by the pend flags raised on the transitioning TCK edge.
   always_comb begin
      state_d          = state_q;
      ir_shift_d       = ir_shift_q;
      idcode_shift_d   = idcode_shift_q;
      user_shift_d     = user_shift_q;
      bypass_d         = bypass_q;
      tdo_d            = tdo_q;
      ir_value_d       = ir_value_q;
      user_dr_out_d    = user_dr_out_q;
      user_dr_update_d = 1'b0;
      upd_ir_pend_d    = 1'b0;
      upd_dr_pend_d    = 1'b0;

      if (tck_rise) begin
         state_d       = tap_next_state(state_q, tms_s);
         upd_ir_pend_d = (state_d == UPDATE_IR);
         upd_dr_pend_d = (state_d == UPDATE_DR);
         case (state_q)
            CAPTURE_IR: ir_shift_d = IR_LEN'(2'b01);
            SHIFT_IR:   ir_shift_d = {tdi_s, ir_shift_q[IR_LEN-1:1]};
            CAPTURE_DR: begin
               if (sel_idcode)    idcode_shift_d = IDCODE_VALUE;
               else if (sel_user) user_shift_d   = dr_capture_in;
               else               bypass_d       = 1'b0;
            end
            SHIFT_DR: begin
               if (sel_idcode)    idcode_shift_d = {tdi_s, idcode_shift_q[31:1]};
               else if (sel_user) user_shift_d   = {tdi_s, user_shift_q[DR_LEN-1:1]};
               else               bypass_d       = tdi_s;
            end
            default: ;
         endcase
      end

      if (tck_fall) begin
         if (state_q == SHIFT_IR)      tdo_d = ir_shift_q[0];
         else if (state_q == SHIFT_DR) tdo_d = dr_bit0;
      end

      if (upd_ir_pend_q) ir_value_d = ir_shift_q;
      if (upd_dr_pend_q && sel_user) begin
         user_dr_out_d    = user_shift_q;
         user_dr_update_d = 1'b1;
      end
      if (state_q == TLR) ir_value_d = INSN_IDCODE;
   end

   always_ff @(posedge ref_clk or posedge rst) begin
      if (rst) begin
         state_q          <= TLR;
         ir_shift_q       <= '0;
         idcode_shift_q   <= '0;
         user_shift_q     <= '0;
         bypass_q         <= 1'b0;
         tdo_q            <= 1'b0;
         ir_value_q       <= INSN_IDCODE;
         user_dr_out_q    <= '0;
         user_dr_update_q <= 1'b0;
         upd_ir_pend_q    <= 1'b0;
         upd_dr_pend_q    <= 1'b0;
      end else begin
         state_q          <= state_d;
         ir_shift_q       <= ir_shift_d;
         idcode_shift_q   <= idcode_shift_d;
         user_shift_q     <= user_shift_d;
         bypass_q         <= bypass_d;
         tdo_q            <= tdo_d;
         ir_value_q       <= ir_value_d;
         user_dr_out_q    <= user_dr_out_d;
         user_dr_update_q <= user_dr_update_d;
         upd_ir_pend_q    <= upd_ir_pend_d;
         upd_dr_pend_q    <= upd_dr_pend_d;
      end
   end

   assign tdo            = tdo_q;
   assign tap_state      = state_q;
   assign ir_value       = ir_value_q;
   assign user_dr_out    = user_dr_out_q;
   assign user_dr_update = user_dr_update_q;

endmodule

// File: tb/tb_jtag_tap_responder.sv
// Directed bench for jtag_tap_responder: drives TCK/TMS/TDI like a JTAG master
// and compares every settled half-TCK against a TCK-level reference model.
module tb_jtag_tap_responder;

   logic        ref_clk = 1'b0;
   logic        rst = 1'b1;
   logic        tck = 1'b0;
   logic        tms = 1'b1;
   logic        tdi = 1'b0;
   logic        tdo;
   logic [3:0]  tap_state;
   logic [7:0]  ir_value;
   logic [31:0] dr_capture_in = 32'h0;
   logic [31:0] user_dr_out;
   logic        user_dr_update;

   jtag_tap_responder dut (
      .ref_clk        (ref_clk),
      .rst            (rst),
      .tck            (tck),
      .tms            (tms),
      .tdi            (tdi),
      .tdo            (tdo),
      .tap_state      (tap_state),
      .ir_value       (ir_value),
      .dr_capture_in  (dr_capture_in),
      .user_dr_out    (user_dr_out),
      .user_dr_update (user_dr_update)
   );

   always #5 ref_clk = ~ref_clk;

   int n_checks = 0;
   int n_pass   = 0;
   int pulse_count = 0;

   // Reference model: TAP graph as lookup tables, registers as plain vectors.
   int          next_on0 [16] = '{1,1,3,4,4,6,6,4,1,10,11,11,13,13,11,1};
   int          next_on1 [16] = '{0,2,9,5,5,8,7,8,2,0,12,12,15,14,15,2};
   int          m_state;
   logic [7:0]  m_ir, m_ir_shift;
   logic [31:0] m_id_shift, m_user_shift, m_user_out;
   logic        m_bypass, m_tdo;
   int          m_pulses;

   always @(negedge ref_clk) if (user_dr_update) pulse_count++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic modelReset();
      m_state = 0; m_ir = 8'h01; m_ir_shift = '0; m_id_shift = '0;
      m_user_shift = '0; m_user_out = '0; m_bypass = 1'b0; m_tdo = 1'b0;
   endtask

   task automatic modelRise(input logic t_ms, input logic t_di);
      case (m_state)
         10: m_ir_shift = 8'h01;
         11: m_ir_shift = (m_ir_shift >> 1) | (8'(t_di) << 7);
         3: begin
            if (m_ir == 8'h01)      m_id_shift   = 32'h1234_5679;
            else if (m_ir == 8'h02) m_user_shift = dr_capture_in;
            else                    m_bypass     = 1'b0;
         end
         4: begin
            if (m_ir == 8'h01)      m_id_shift   = (m_id_shift >> 1) | (32'(t_di) << 31);
            else if (m_ir == 8'h02) m_user_shift = (m_user_shift >> 1) | (32'(t_di) << 31);
            else                    m_bypass     = t_di;
         end
         default: ;
      endcase
      m_state = t_ms ? next_on1[m_state] : next_on0[m_state];
      if (m_state == 15) m_ir = m_ir_shift;
      if (m_state == 8 && m_ir == 8'h02) begin
         m_user_out = m_user_shift;
         m_pulses++;
      end
      if (m_state == 0) m_ir = 8'h01;
   endtask

   task automatic modelFall();
      if (m_state == 11) m_tdo = m_ir_shift[0];
      else if (m_state == 4)
         m_tdo = (m_ir == 8'h01) ? m_id_shift[0] : (m_ir == 8'h02) ? m_user_shift[0] : m_bypass;
   endtask

   task automatic waitRef(input int n);
      repeat (n) @(posedge ref_clk);
      #1;
   endtask

   task automatic checkOutput(input string phase);
      check({"tap_state@", phase}, 64'(tap_state), 64'(m_state));
      check({"ir_value@", phase}, 64'(ir_value), 64'(m_ir));
      check({"tdo@", phase}, 64'(tdo), 64'(m_tdo));
      check({"user_dr_out@", phase}, 64'(user_dr_out), 64'(m_user_out));
      check({"pulses@", phase}, 64'(pulse_count), 64'(m_pulses));
   endtask

   // One full TCK period; returns TDO as the master would sample it at the rise.
   task automatic applyStimulus(input logic t_ms, input logic t_di, output logic tdo_sample);
      tms = t_ms;
      tdi = t_di;
      tdo_sample = tdo;
      tck = 1'b1;
      waitRef(5);
      modelRise(t_ms, t_di);
      checkOutput("rise");
      tck = 1'b0;
      waitRef(5);
      modelFall();
      checkOutput("fall");
   endtask

   task automatic shiftBits(input int n, input logic [63:0] din, output logic [63:0] dout);
      logic s;
      dout = '0;
      for (int i = 0; i < n; i++) begin
         applyStimulus(i == n - 1, din[i], s);
         dout[i] = s;
      end
      applyStimulus(1'b1, 1'b0, s);
      applyStimulus(1'b0, 1'b0, s);
   endtask

   task automatic enterShiftDrFromRti();
      logic s;
      applyStimulus(1'b1, 1'b0, s);
      applyStimulus(1'b0, 1'b0, s);
      applyStimulus(1'b0, 1'b0, s);
   endtask

   task automatic loadIr(input logic [7:0] v, output logic [63:0] captured);
      logic s;
      applyStimulus(1'b1, 1'b0, s);
      applyStimulus(1'b1, 1'b0, s);
      applyStimulus(1'b0, 1'b0, s);
      applyStimulus(1'b0, 1'b0, s);
      shiftBits(8, 64'(v), captured);
   endtask

   task automatic idcodeReadFromTlr(input string name);
      logic        s;
      logic [63:0] dout;
      applyStimulus(1'b0, 1'b0, s);
      enterShiftDrFromRti();
      check({name, "_state"}, 64'(tap_state), 64'd4);
      shiftBits(32, 64'd0, dout);
      check({name, "_value"}, dout, 64'h1234_5679);
   endtask

   initial begin
      logic        s;
      logic [63:0] dout;
      int          pulses_before;
      logic [31:0] out_before;

      modelReset();
      m_pulses = 0;
      waitRef(3);
      rst = 1'b0;
      waitRef(1);
      check("reset_state", 64'(tap_state), 64'd0);
      check("reset_ir", 64'(ir_value), 64'h01);
      check("reset_tdo", 64'(tdo), 64'd0);
      check("reset_update", 64'(user_dr_update), 64'd0);
      check("reset_user_out", 64'(user_dr_out), 64'd0);

      idcodeReadFromTlr("idcode");

      loadIr(8'hFF, dout);
      check("capture_ir_bits", dout[1:0], 64'b01);
      check("bypass_ir", 64'(ir_value), 64'hFF);
      enterShiftDrFromRti();
      shiftBits(4, 64'b1101, dout);
      check("bypass_tdo", dout, 64'b1010);

      dr_capture_in = 32'hA5A5_0000;
      pulses_before = pulse_count;
      loadIr(8'h02, dout);
      check("user_ir", 64'(ir_value), 64'h02);
      enterShiftDrFromRti();
      shiftBits(32, 64'hDEAD_BEEF, dout);
      check("user_tdo", dout, 64'hA5A5_0000);
      check("user_out", 64'(user_dr_out), 64'hDEAD_BEEF);
      check("user_pulses", 64'(pulse_count - pulses_before), 64'd1);

      enterShiftDrFromRti();
      out_before = user_dr_out;
      repeat (5) applyStimulus(1'b1, 1'b1, s);
      check("soft_reset_state", 64'(tap_state), 64'd0);
      check("soft_reset_ir", 64'(ir_value), 64'h01);
      check("soft_reset_user_out", 64'(user_dr_out), 64'(m_user_out));
      if (m_user_out == out_before)
         check("soft_reset_user_hold", 64'(user_dr_out), 64'(out_before));

      applyStimulus(1'b0, 1'b0, s);
      enterShiftDrFromRti();
      for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, s);
      pulses_before = pulse_count;
      @(posedge ref_clk);
      #3 rst = 1'b1;
      #1;
      check("async_state", 64'(tap_state), 64'd0);
      check("async_ir", 64'(ir_value), 64'h01);
      check("async_tdo", 64'(tdo), 64'd0);
      check("async_user_out", 64'(user_dr_out), 64'd0);
      check("async_update", 64'(user_dr_update), 64'd0);
      modelReset();
      waitRef(3);
      rst = 1'b0;
      waitRef(2);
      check("async_no_pulse", 64'(pulse_count - pulses_before), 64'd0);
      idcodeReadFromTlr("idcode_after_rst");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
